// File: rtl/equilibrium_stepper_ctrl.sv
// Stepper-motor controller: homes against the left end switch, then performs
// absolute moves with a fixed-rate step generator and limit/abort protection.
module equilibrium_stepper_ctrl #(
    parameter int unsigned STEP_PERIOD   = 50000,
    parameter int unsigned BACKOFF_STEPS = 16,
    parameter int unsigned POS_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_home,
    input  logic             move_req,
    input  logic [POS_W-1:0] target_pos,
    input  logic             abort,
    input  logic             end_left,
    input  logic             end_right,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] current_pos,
    output logic             busy,
    output logic             done,
    output logic             homed,
    output logic             fault,
    output logic [2:0]       db_estado
);

    localparam int unsigned      CNT_W       = (STEP_PERIOD > 2) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STEP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(STEP_PERIOD / 2);
    localparam logic [POS_W-1:0] BACKOFF_POS = POS_W'(BACKOFF_STEPS);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_HOME_SEEK    = 3'd1,
        S_HOME_BACKOFF = 3'd2,
        S_READY        = 3'd3,
        S_MOVE_SETUP   = 3'd4,
        S_MOVE         = 3'd5,
        S_FAULT        = 3'd7
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == S_HOME_SEEK) || (s == S_HOME_BACKOFF) ||
               (s == S_MOVE_SETUP) || (s == S_MOVE);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W-1:0]   tgt_q, tgt_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic               setup_q, setup_d;
    logic               done_q, done_d;
    logic               homed_q, homed_d;
    logic               fault_q, fault_d;
    logic               busy_q;
    logic [1:0]         sl_q, sr_q;

    logic               left_s, right_s, cnt_wrap, step_hi_nxt, limit_hit, home_req;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [POS_W-1:0]   pos_step;

    assign left_s      = sl_q[1];
    assign right_s     = sr_q[1];
    assign cnt_wrap    = (cnt_q == CNT_LAST);
    assign cnt_nxt     = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    assign step_hi_nxt = (cnt_nxt < CNT_HALF);
    assign pos_step    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    assign home_req    = start_home && !abort;

    // A switch on the side we are travelling toward, or both switches at once, is a fault.
    assign limit_hit = (left_s && right_s) ||
                       ((state_q == S_HOME_SEEK) && right_s) ||
                       ((state_q == S_MOVE) && ((!dir_q && left_s) || (dir_q && right_s)));

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        step_d  = 1'b0;
        dir_d   = dir_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        setup_d = 1'b0;
        done_d  = 1'b0;
        homed_d = homed_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                if (home_req) state_d = S_HOME_SEEK;
            end
            S_HOME_SEEK: begin
                if (left_s) begin
                    state_d = S_HOME_BACKOFF;
                    pos_d   = '0;
                    dir_d   = 1'b1;
                    setup_d = 1'b1;
                end else begin
                    cnt_d  = cnt_nxt;
                    step_d = step_hi_nxt;
                end
            end
            S_HOME_BACKOFF: begin
                if (setup_q) begin
                    step_d = 1'b1;
                    pos_d  = pos_step;
                end else if (cnt_wrap && (pos_q == BACKOFF_POS)) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                    homed_d = 1'b1;
                end else begin
                    cnt_d  = cnt_nxt;
                    step_d = step_hi_nxt;
                    if (cnt_wrap) pos_d = pos_step;
                end
            end
            S_READY: begin
                if (home_req) begin
                    state_d = S_HOME_SEEK;
                end else if (move_req && !abort) begin
                    if (target_pos == pos_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_MOVE_SETUP;
                        tgt_d   = target_pos;
                        dir_d   = (target_pos > pos_q);
                    end
                end
            end
            S_MOVE_SETUP: begin
                state_d = S_MOVE;
                step_d  = 1'b1;
                pos_d   = pos_step;
            end
            S_MOVE: begin
                if (cnt_wrap && (pos_q == tgt_q)) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_nxt;
                    step_d = step_hi_nxt;
                    if (cnt_wrap) pos_d = pos_step;
                end
            end
            S_FAULT: begin
                if (home_req) state_d = S_HOME_SEEK;
            end
            default: state_d = S_IDLE;
        endcase

        // Entering homing invalidates the position; the first seek step rises immediately.
        if (state_d == S_HOME_SEEK && state_q != S_HOME_SEEK) begin
            dir_d   = 1'b0;
            step_d  = 1'b1;
            cnt_d   = '0;
            homed_d = 1'b0;
            fault_d = 1'b0;
        end

        if (abort && is_busy(state_q)) begin
            state_d = homed_q ? S_READY : S_IDLE;
            cnt_d   = '0;
            step_d  = 1'b0;
            pos_d   = pos_q;
            dir_d   = dir_q;
            setup_d = 1'b0;
            done_d  = 1'b0;
        end

        if (limit_hit) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            step_d  = 1'b0;
            pos_d   = pos_q;
            dir_d   = dir_q;
            setup_d = 1'b0;
            done_d  = 1'b0;
            homed_d = 1'b0;
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            tgt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            setup_q <= 1'b0;
            done_q  <= 1'b0;
            homed_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            sl_q    <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            setup_q <= setup_d;
            done_q  <= done_d;
            homed_q <= homed_d;
            fault_q <= fault_d;
            busy_q  <= is_busy(state_d);
            sl_q    <= {sl_q[0], end_left};
            sr_q    <= {sr_q[0], end_right};
        end
    end

    assign step        = step_q;
    assign dir         = dir_q;
    assign current_pos = pos_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign homed       = homed_q;
    assign fault       = fault_q;
    assign db_estado   = state_q;

endmodule

// File: tb/tb_equilibrium_stepper_ctrl.sv
// Directed bench for equilibrium_stepper_ctrl with STEP_PERIOD=4, BACKOFF_STEPS=2.
module tb_equilibrium_stepper_ctrl;

    localparam int unsigned POS_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start_home, move_req, abort, end_left, end_right;
    logic [POS_W-1:0] target_pos;
    logic             step, dir, busy, done, homed, fault;
    logic [POS_W-1:0] current_pos;
    logic [2:0]       db_estado;

    int checks = 0;
    int errors = 0;

    equilibrium_stepper_ctrl #(
        .STEP_PERIOD(4), .BACKOFF_STEPS(2), .POS_W(POS_W)
    ) dut (
        .clock(clock), .reset(reset), .start_home(start_home), .move_req(move_req),
        .target_pos(target_pos), .abort(abort), .end_left(end_left), .end_right(end_right),
        .step(step), .dir(dir), .current_pos(current_pos), .busy(busy), .done(done),
        .homed(homed), .fault(fault), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic sh, mr; int tgt; logic ab, el, er;
        logic e_step, e_dir; int e_pos; logic e_busy, e_done, e_homed, e_fault; int e_st;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic sh, mr, input int tgt, input logic ab, el, er,
                                input logic s, d, input int p, input logic b, dn, h, f,
                                input int st);
        vec_t v;
        v.sh = sh; v.mr = mr; v.tgt = tgt; v.ab = ab; v.el = el; v.er = er;
        v.e_step = s; v.e_dir = d; v.e_pos = p; v.e_busy = b; v.e_done = dn;
        v.e_homed = h; v.e_fault = f; v.e_st = st;
        vq.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic s, d, input int p,
                             input logic b, dn, h, f, input int st);
        chk({tag, " step"}, 32'(step), 32'(s));
        chk({tag, " dir"}, 32'(dir), 32'(d));
        chk({tag, " pos"}, 32'(current_pos), 32'(p));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(dn));
        chk({tag, " homed"}, 32'(homed), 32'(h));
        chk({tag, " fault"}, 32'(fault), 32'(f));
        chk({tag, " state"}, 32'(db_estado), 32'(st));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_fault(input string tag, input int budget);
        int n = 0;
        while (fault !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " fault_seen"}, 32'(fault), 32'd1);
    endtask

    task automatic clear_inputs();
        start_home = 0; move_req = 0; abort = 0; end_left = 0; end_right = 0;
        target_pos = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        //  sh mr tgt ab el er | step dir pos busy done homed fault st
        add(0, 1, 7, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);   // move_req ignored in IDLE
        add(1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);   // abort blocks start_home
        add(1, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);   // seek step 1
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);   // seek step 2
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 1);   // seek step 3
        add(0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 0, 0, 0, 1);   // end_left rises
        add(0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, 0, 0, 0, 2);   // backoff dir setup
        add(0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   1, 1, 2, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   1, 1, 2, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   0, 1, 2, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   0, 1, 2, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1, 1, 0, 3);   // homed, done
        add(0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 0, 1, 0, 3);
        add(0, 1, 5, 0, 0, 0,   0, 1, 2, 1, 0, 1, 0, 4);   // move to 5: setup
        add(0, 0, 0, 0, 0, 0,   1, 1, 3, 1, 0, 1, 0, 5);   // MOVE entry
        add(0, 0, 0, 0, 0, 0,   1, 1, 3, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 3, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 3, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   1, 1, 4, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   1, 1, 4, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 4, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 4, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   1, 1, 5, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   1, 1, 5, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 5, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 5, 1, 0, 1, 0, 5);
        add(0, 0, 0, 0, 0, 0,   0, 1, 5, 0, 1, 1, 0, 3);   // done 12 cycles after entry
        add(0, 1, 5, 0, 0, 0,   0, 1, 5, 0, 1, 1, 0, 3);   // equal target: done, no step
        add(0, 0, 0, 0, 0, 0,   0, 1, 5, 0, 0, 1, 0, 3);

        repeat (3) @(posedge clock);
        #1;
        check_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            start_home = vq[i].sh; move_req = vq[i].mr; target_pos = POS_W'(vq[i].tgt);
            abort = vq[i].ab; end_left = vq[i].el; end_right = vq[i].er;
            tick();
            check_all($sformatf("vec%0d", i), vq[i].e_step, vq[i].e_dir, vq[i].e_pos,
                      vq[i].e_busy, vq[i].e_done, vq[i].e_homed, vq[i].e_fault, vq[i].e_st);
        end
        clear_inputs();

        // Abort two steps into a move from 5 toward 0.
        move_req = 1; target_pos = 0;
        tick();
        move_req = 0;
        chk("abort setup dir", 32'(dir), 32'd0);
        tick();
        chk("abort step1 pos", 32'(current_pos), 32'd4);
        repeat (4) tick();
        chk("abort step2 pos", 32'(current_pos), 32'd3);
        chk("abort step2 step", 32'(step), 32'd1);
        tick();
        abort = 1;
        tick();
        check_all("abort", 0, 0, 3, 0, 0, 1, 0, 3);
        move_req = 1; target_pos = 7;
        tick();
        chk("abort blocks move state", 32'(db_estado), 32'd3);
        chk("abort blocks move done", 32'(done), 32'd0);
        clear_inputs();
        tick();
        chk("abort no late done", 32'(done), 32'd0);

        // Left limit hit while moving left.
        move_req = 1; target_pos = 0;
        tick();
        move_req = 0;
        tick();
        end_left = 1;
        wait_fault("limit", 8);
        check_all("limit", 0, 0, 2, 0, 0, 0, 1, 7);
        move_req = 1; target_pos = 9;
        tick();
        move_req = 0;
        chk("fault ignores move", 32'(db_estado), 32'd7);
        start_home = 1;
        tick();
        start_home = 0; end_left = 0;
        chk("fault clear state", 32'(db_estado), 32'd1);
        chk("fault clear flag", 32'(fault), 32'd0);
        wait_done("rehome1", 40);
        chk("rehome1 pos", 32'(current_pos), 32'd2);
        chk("rehome1 homed", 32'(homed), 32'd1);

        // start_home beats move_req in the same cycle.
        tick();
        start_home = 1; move_req = 1; target_pos = 9;
        tick();
        start_home = 0; move_req = 0;
        chk("prio state", 32'(db_estado), 32'd1);
        chk("prio dir", 32'(dir), 32'd0);
        chk("prio step", 32'(step), 32'd1);
        repeat (2) tick();
        end_left = 1;
        repeat (3) tick();
        end_left = 0;
        wait_done("rehome2", 40);
        chk("rehome2 pos", 32'(current_pos), 32'd2);

        // Asynchronous reset while a step is high.
        tick();
        move_req = 1; target_pos = 4;
        tick();
        move_req = 0;
        tick();
        chk("pre_reset step", 32'(step), 32'd1);
        #1 reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("after_reset state", 32'(db_estado), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
